// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch sequencer: registers one branch, resolves it in a single cycle,
// and on a mispredict drives a redirect handshake followed by a timed pipeline flush.
module branch_resolve_ctrl #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill_i,
    input  logic             br_valid_i,
    output logic             br_ready_o,
    input  logic [XLEN-1:0]  br_pc_i,
    input  logic [XLEN-1:0]  br_imm_i,
    input  logic [XLEN-1:0]  br_reg1_i,
    input  logic [XLEN-1:0]  br_reg2_i,
    input  logic [2:0]       br_type_i,
    input  logic             br_pred_taken_i,
    output logic             resolve_valid_o,
    output logic             resolve_taken_o,
    output logic             resolve_mispredict_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam int unsigned FcW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StEval, StRedirect, StFlush} state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, imm_q, reg1_q, reg2_q;
    logic [2:0]       type_q;
    logic             pred_q;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FcW-1:0]   flush_cnt_q, flush_cnt_d;
    logic             accept;
    logic             taken;
    logic             mispredict;
    logic [XLEN-1:0]  target;

    always_comb begin
        unique case (type_q)
            3'b010:  taken = (reg1_q == reg2_q);
            3'b001:  taken = (reg1_q != reg2_q);
            3'b100:  taken = ($signed(reg1_q) <  $signed(reg2_q));
            3'b101:  taken = ($signed(reg1_q) >= $signed(reg2_q));
            3'b110:  taken = (reg1_q <  reg2_q);
            3'b111:  taken = (reg1_q >= reg2_q);
            default: taken = 1'b0;
        endcase
        target     = taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        mispredict = taken ^ pred_q;
    end

    always_comb begin
        state_d          = state_q;
        redirect_pc_d    = redirect_pc_q;
        cnt_d            = cnt_q;
        flush_cnt_d      = flush_cnt_q;
        accept           = 1'b0;
        br_ready_o       = 1'b0;
        resolve_valid_o  = 1'b0;
        redirect_valid_o = 1'b0;
        flush_o          = 1'b0;

        // Kill overrides every state: drop any in-flight branch without side effects.
        if (kill_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    br_ready_o = 1'b1;
                    if (br_valid_i) begin
                        accept  = 1'b1;
                        state_d = StEval;
                    end
                end
                StEval: begin
                    resolve_valid_o = 1'b1;
                    redirect_pc_d   = target;
                    if (mispredict) begin
                        state_d = StRedirect;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StRedirect: begin
                    redirect_valid_o = 1'b1;
                    if (redirect_ready_i) begin
                        if (FLUSH_CYCLES == 0) begin
                            state_d = StIdle;
                        end else begin
                            state_d     = StFlush;
                            flush_cnt_d = FcW'(FLUSH_CYCLES);
                        end
                    end
                end
                StFlush: begin
                    flush_o = (flush_cnt_q != '0);
                    if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q <= FcW'(1)) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign resolve_taken_o      = resolve_valid_o & taken;
    assign resolve_mispredict_o = resolve_valid_o & mispredict;
    assign redirect_pc_o        = redirect_pc_q;
    assign mispredict_cnt_o     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            imm_q  <= '0;
            reg1_q <= '0;
            reg2_q <= '0;
            type_q <= '0;
            pred_q <= 1'b0;
        end else if (accept) begin
            pc_q   <= br_pc_i;
            imm_q  <= br_imm_i;
            reg1_q <= br_reg1_i;
            reg2_q <= br_reg2_i;
            type_q <= br_type_i;
            pred_q <= br_pred_taken_i;
        end
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequencing controller for the 64-bit branch comparator path in the EX stage.
- Accepts one branch at a time from issue, registers operands, and resolves taken/not-taken with the team's funct3 branch encoding.
- Compares the outcome with the fetch-stage prediction. On a mispredict, drives a redirect handshake to fetch, then holds a pipeline flush for a fixed number of cycles.
- Keeps a saturating mispredict counter for performance monitoring.

Parameters:
- XLEN, 64, operand/PC width.
- FLUSH_CYCLES, 2, cycles flush is held after redirect handshake (0 allowed = no flush phase).
- CNT_W, 32, mispredict counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- kill  in  1  higher-priority pipeline kill (exception/interrupt).
- br_valid  in  1  branch request valid.
- br_ready  out  1  controller can accept a branch.
- br_pc  in  XLEN  branch instruction PC.
- br_imm  in  XLEN  sign-extended branch offset.
- br_reg1  in  XLEN  source operand 1.
- br_reg2  in  XLEN  source operand 2.
- br_type  in  3  branch type (funct3, team encoding).
- br_pred_taken  in  1  fetch prediction for this branch.
- resolve_valid  out  1  one-cycle pulse: branch resolved.
- resolve_taken  out  1  actual outcome, valid with resolve_valid.
- resolve_mispredict  out  1  outcome != prediction, valid with resolve_valid.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  XLEN  correct next PC.
- flush  out  1  flush younger pipeline stages.
- mispredict_cnt  out  CNT_W  saturating mispredict count.

Behaviour:
- Reset (rst_n=0, async): state IDLE; all registered outputs 0, including redirect_pc and mispredict_cnt. br_ready=1 once rst_n=1 and kill=0.
- br_ready = (state==IDLE) && !kill. Accept on br_valid && br_ready; capture pc/imm/reg1/reg2/type/pred into registers, then go to EVAL.
- Branch type encoding:
  - 010 BEQ; 001 BNE.
  - 100 BLT (signed); 101 BGE (signed).
  - 110 BLTU (unsigned); 111 BGEU (unsigned).
  - 000 and 011 are invalid and resolve not-taken.
- EVAL (exactly 1 cycle, from registered operands):
  - taken per encoding.
  - target = taken ? pc+imm : pc+4. Arithmetic is modulo 2^XLEN; wrap-around is not an error.
  - resolve_valid=1 with resolve_taken and resolve_mispredict = taken ^ pred. redirect_pc is loaded with target.
  - If mispredict: go to REDIRECT and increment mispredict_cnt, saturating at all-ones. Otherwise go to IDLE.
  - Accept-to-resolve latency is 1 cycle. Peak throughput is one branch per 2 cycles.
- REDIRECT:
  - redirect_valid=1; redirect_pc stable until handshake.
  - On redirect_ready: go to FLUSH with counter=FLUSH_CYCLES, or to IDLE if FLUSH_CYCLES==0.
  - redirect_valid deasserts the cycle after handshake.
- FLUSH: flush=1 while counter!=0; counter decrements each cycle; go to IDLE when it reaches 0. flush is high for exactly FLUSH_CYCLES cycles.
- kill (any state, synchronous priority over everything):
  - Next state IDLE.
  - redirect_valid, flush, resolve_valid forced to 0 in that cycle and after.
  - A branch in EVAL under kill is dropped; no resolve pulse and no counter increment.
  - No branch is accepted while kill=1.
- br_valid while not IDLE is ignored; issue holds it until accepted.
- rst_n asserted mid-operation aborts immediately to reset values; an in-flight redirect is lost.

Test Plan:
- BEQ: reg1=reg2=0x5, pc=0x1000, imm=0x40, pred=0 → resolve pulse 1 cycle after accept, taken=1, mispredict=1; redirect_pc=0x1040; flush high 2 cycles after handshake; mispredict_cnt=1.
- BLT vs BLTU: reg1=0xFFFF_FFFF_FFFF_FFFF, reg2=1 → BLT taken, BLTU not-taken. Invalid types 000/011 → not-taken.
- Correct prediction: BNE reg1=1, reg2=2, pred=1 → taken=1, mispredict=0, no redirect_valid, br_ready back high 2 cycles after accept.
- Backpressure: mispredict with redirect_ready low 5 cycles → redirect_valid and redirect_pc stable; flush only after handshake; br_valid ignored throughout.
- Wrap and kill:
  - pc=0xFFFF_FFFF_FFFF_FFFC, not-taken mispredict → redirect_pc=0x0.
  - kill asserted in EVAL → no resolve_valid, counter unchanged, IDLE next cycle.
- Saturation and reset: CNT_W=2, 4 mispredicts → count stays 3. Drop rst_n during FLUSH → flush and count return to 0 immediately, with no clock edge needed.
